chacha_xor_stream: RTL and testbench
====================================

CHACHA_XOR_STREAM -- requirements
Module: chacha_xor_stream

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 64; keystream bytes consumed per block; power of two, 1..64.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port block_ready  input  1  keystream block is computed and readable, level.
REQ-005 SHALL have port block_next  output  1  one-cycle pulse requesting the next keystream block.
REQ-006 SHALL have port hold_out  output  1  freezes the keystream core while its block is being read.
REQ-007 SHALL have port addr_out  output  6  keystream byte address to the core.
REQ-008 SHALL have port ks_data  input  8  keystream byte at addr_out, valid in the same cycle (combinational read).
REQ-009 SHALL have port pt_valid  input  1  plaintext byte offered.
REQ-010 SHALL have port pt_ready  output  1  plaintext byte accepted when pt_valid && pt_ready.
REQ-011 SHALL have port pt_data  input  8  plaintext byte.
REQ-012 SHALL have port pt_last  input  1  marks final byte of a message, qualified by pt_valid.
REQ-013 SHALL have port ct_valid  output  1  ciphertext byte available.
REQ-014 SHALL have port ct_ready  input  1  downstream accepts when ct_valid && ct_ready.
REQ-015 SHALL have port ct_data  output  8  ciphertext byte.
REQ-016 SHALL have port ct_last  output  1  final-byte marker travelling with ct_data.

Function
REQ-017 SHALL implement states WAIT, STREAM, REFILL with a byte index idx of width log2(BLOCK_BYTES), minimum 1 bit.
REQ-018 SHALL, in WAIT, drive pt_ready=0, hold_out=0, addr_out=0, and move to STREAM on the next edge when block_ready=1, except in the first WAIT cycle after REFILL, when block_ready is ignored.
REQ-019 SHALL, in STREAM, drive hold_out=1 and addr_out=idx zero-extended to 6 bits.
REQ-020 SHALL, in STREAM, drive pt_ready = !ct_valid || ct_ready; at all other times pt_ready=0.
REQ-021 SHALL, on a plaintext transfer, register ct_data = pt_data XOR ks_data, ct_last = pt_last, ct_valid = 1, and increment idx; latency is 1 cycle from transfer to ct_valid.
REQ-022 SHALL hold ct_data and ct_last stable while ct_valid=1 and ct_ready=0.
REQ-023 SHALL clear ct_valid after a ct transfer that is not accompanied by a new pt transfer in the same cycle; a simultaneous pt transfer reloads the register with ct_valid staying 1, giving full throughput of 1 byte/cycle.
REQ-024 SHALL move to REFILL after a transfer with idx = BLOCK_BYTES-1 or pt_last=1 (either or both); remaining keystream bytes are discarded and never reused.
REQ-025 SHALL, in REFILL, assert block_next=1 for exactly one cycle, drive hold_out=0, reset idx to 0, and move to WAIT unconditionally.
REQ-026 SHALL keep block_next=0 in all states other than REFILL.
REQ-027 SHALL leave an already-registered ct byte pending across REFILL and WAIT until it is accepted.
REQ-028 SHALL ignore pt_data and pt_last when pt_valid=0.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force state=WAIT, idx=0, ct_valid=0, ct_data=0, ct_last=0, block_next=0, hold_out=0, addr_out=0, pt_ready=0.
REQ-030 SHALL, on reset mid-STREAM, discard any pending ct byte and the partially consumed block; after release, wait for block_ready.

Verification
REQ-031 SHALL pass this check: with ks byte k = k (ks_data = addr_out), block_ready=1, ct_ready=1, and 64 plaintext bytes 0xFF back-to-back -> ct_data = 0xFF^k for k=0..63, one per cycle, then block_next pulses once.
REQ-032 SHALL pass this check: pt_last=1 on byte 5 -> ct_last=1 on ct byte 5 only, REFILL follows, and the next message starts at addr_out=0 of a new block.
REQ-033 SHALL pass this check: ct_ready=0 for 3 cycles after the first transfer -> pt_ready=0, and ct_data stays constant for those 3 cycles; no byte is lost or duplicated.
REQ-034 SHALL pass this check: block_ready held 1 through REFILL -> exactly one block_next pulse, and STREAM is re-entered no earlier than the second WAIT cycle.
REQ-035 SHALL pass this check: rst_n=0 at idx=17 with ct_valid=1 -> all outputs 0 immediately, without waiting for a clock edge; after release, addr_out=0 and STREAM re-enters only on block_ready.
REQ-036 SHALL pass this check: BLOCK_BYTES=4, 10 bytes streamed -> block_next pulses after bytes 4 and 8, and addr_out cycles 0..3.

Source files
------------

// File: rtl/chacha_xor_stream.sv
// XORs a plaintext byte stream with keystream bytes read from a ChaCha core,
// consuming one keystream block per message or per BLOCK_BYTES bytes, whichever ends first.
module chacha_xor_stream #(
    parameter int BLOCK_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       block_ready,
    output logic       block_next,
    output logic       hold_out,
    output logic [5:0] addr_out,
    input  logic [7:0] ks_data,
    input  logic       pt_valid,
    output logic       pt_ready,
    input  logic [7:0] pt_data,
    input  logic       pt_last,
    output logic       ct_valid,
    input  logic       ct_ready,
    output logic [7:0] ct_data,
    output logic       ct_last
);

    localparam int IDX_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {
        WAIT,
        STREAM,
        REFILL
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             first_wait;
    logic             pt_fire;
    logic             ct_fire;
    logic             block_end;

    assign pt_fire   = pt_valid && pt_ready;
    assign ct_fire   = ct_valid && ct_ready;
    assign block_end = pt_fire && ((idx == LAST_IDX) || pt_last);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        case (state)
            WAIT:    if (block_ready && !first_wait) state_next = STREAM;
            STREAM:  if (block_end) state_next = REFILL;
            REFILL:  state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    always_comb begin
        block_next = 1'b0;
        hold_out   = 1'b0;
        addr_out   = 6'd0;
        pt_ready   = 1'b0;
        case (state)
            STREAM: begin
                hold_out = 1'b1;
                addr_out = 6'(idx);
                pt_ready = !ct_valid || ct_ready;
            end
            REFILL:  block_next = 1'b1;
            default: ;
        endcase
    end

    // The core still shows the old block ready right after block_next, so skip one WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            first_wait <= 1'b0;
        end else begin
            first_wait <= (state == REFILL);
            if (state == REFILL) begin
                idx <= '0;
            end else if (pt_fire) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Output register: a new pt transfer reloads it even while the old byte leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ct_valid <= 1'b0;
            ct_data  <= 8'd0;
            ct_last  <= 1'b0;
        end else if (pt_fire) begin
            ct_valid <= 1'b1;
            ct_data  <= pt_data ^ ks_data;
            ct_last  <= pt_last;
        end else if (ct_fire) begin
            ct_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chacha_xor_stream.sv
// Scoreboard bench for chacha_xor_stream: a 64-byte-block instance (a) and a 4-byte-block instance (b),
// keystream byte k = address k.
module tb_chacha_xor_stream;

    logic clk;
    logic rst_n;

    logic       block_ready_a, block_next_a, hold_out_a;
    logic [5:0] addr_out_a;
    logic [7:0] ks_a;
    logic       pt_valid_a, pt_ready_a, pt_last_a;
    logic [7:0] pt_data_a;
    logic       ct_valid_a, ct_ready_a, ct_last_a;
    logic [7:0] ct_data_a;

    logic       block_ready_b, block_next_b, hold_out_b;
    logic [5:0] addr_out_b;
    logic [7:0] ks_b;
    logic       pt_valid_b, pt_ready_b, pt_last_b;
    logic [7:0] pt_data_b;
    logic       ct_valid_b, ct_ready_b, ct_last_b;
    logic [7:0] ct_data_b;

    assign ks_a = {2'b00, addr_out_a};
    assign ks_b = {2'b00, addr_out_b};

    chacha_xor_stream #(.BLOCK_BYTES(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .block_ready(block_ready_a), .block_next(block_next_a),
        .hold_out(hold_out_a), .addr_out(addr_out_a), .ks_data(ks_a),
        .pt_valid(pt_valid_a), .pt_ready(pt_ready_a), .pt_data(pt_data_a), .pt_last(pt_last_a),
        .ct_valid(ct_valid_a), .ct_ready(ct_ready_a), .ct_data(ct_data_a), .ct_last(ct_last_a)
    );

    chacha_xor_stream #(.BLOCK_BYTES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .block_ready(block_ready_b), .block_next(block_next_b),
        .hold_out(hold_out_b), .addr_out(addr_out_b), .ks_data(ks_b),
        .pt_valid(pt_valid_b), .pt_ready(pt_ready_b), .pt_data(pt_data_b), .pt_last(pt_last_b),
        .ct_valid(ct_valid_b), .ct_ready(ct_ready_b), .ct_data(ct_data_b), .ct_last(ct_last_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bn_a = 0;
    int bn_b = 0;
    int popped_b = 0;
    int since_bn = 100;
    int exp_a = 0;
    int exp_b = 0;
    logic [8:0] sb_a[$];
    logic [8:0] sb_b[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a negedge; returns at the negedge following the transfer, valid still high.
    task automatic send(input int sel, input logic [7:0] d, input logic last);
        int  n = 0;
        logic rdy;
        if (sel == 0) begin
            pt_valid_a = 1'b1; pt_data_a = d; pt_last_a = last;
        end else begin
            pt_valid_b = 1'b1; pt_data_b = d; pt_last_b = last;
        end
        #1;
        rdy = (sel == 0) ? pt_ready_a : pt_ready_b;
        while (!rdy && n < 200) begin
            @(negedge clk);
            #1;
            rdy = (sel == 0) ? pt_ready_a : pt_ready_b;
            n++;
        end
        if (!rdy) begin
            check("send_timeout", 32'd0, 32'd1);
        end else if (sel == 0) begin
            sb_a.push_back({last, d ^ 8'(exp_a)});
            exp_a = (last || exp_a == 63) ? 0 : exp_a + 1;
        end else begin
            sb_b.push_back({last, d ^ 8'(exp_b)});
            exp_b = (last || exp_b == 3) ? 0 : exp_b + 1;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int sel);
        int n = 0;
        pt_valid_a = 1'b0;
        pt_valid_b = 1'b0;
        while (((sel == 0) ? sb_a.size() : sb_b.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", (sel == 0) ? sb_a.size() : sb_b.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Monitor for instance a: scoreboard pop, stall stability, REFILL/WAIT spacing, idle outputs.
    logic       prev_stall = 1'b0;
    logic       prev_hold = 1'b0;
    logic       prev_bn = 1'b0;
    logic [8:0] held = '0;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_hold  = 1'b0;
            prev_bn    = 1'b0;
        end else begin
            if (ct_valid_a && ct_ready_a) begin
                if (sb_a.size() == 0) check("a_unexpected_ct", {ct_last_a, ct_data_a}, 32'h1ff);
                else check("a_ct", {ct_last_a, ct_data_a}, sb_a.pop_front());
            end
            if (prev_stall && ct_valid_a) check("a_stall_stable", {ct_last_a, ct_data_a}, held);
            if (ct_valid_a && !ct_ready_a) check("a_stall_pt_ready", pt_ready_a, 0);
            prev_stall = ct_valid_a && !ct_ready_a;
            held       = {ct_last_a, ct_data_a};
            since_bn++;
            if (block_next_a) begin
                check("a_bn_single", prev_bn, 0);
                bn_a++;
                since_bn = 0;
            end
            if (hold_out_a && !prev_hold && bn_a > 0)
                check("a_refill_gap_ok", since_bn >= 3, 1);
            if (!hold_out_a) check("a_idle_addr_ready", {addr_out_a, pt_ready_a}, 0);
            prev_hold = hold_out_a;
            prev_bn   = block_next_a;
        end
    end

    // Monitor for instance b: scoreboard pop and block_next position in the byte stream.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (ct_valid_b && ct_ready_b) begin
                if (sb_b.size() == 0) check("b_unexpected_ct", {ct_last_b, ct_data_b}, 32'h1ff);
                else check("b_ct", {ct_last_b, ct_data_b}, sb_b.pop_front());
                popped_b++;
            end
            if (hold_out_b) check("b_addr_range", addr_out_b < 6'd4, 1);
            if (block_next_b) begin
                bn_b++;
                check("b_bn_after_bytes", popped_b, 4 * bn_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n = 1'b1;
        block_ready_a = 1'b1; pt_valid_a = 1'b0; pt_data_a = 8'h00; pt_last_a = 1'b0; ct_ready_a = 1'b1;
        block_ready_b = 1'b1; pt_valid_b = 1'b0; pt_data_b = 8'h00; pt_last_b = 1'b0; ct_ready_b = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_a_outputs", {block_next_a, hold_out_a, addr_out_a, pt_ready_a, ct_valid_a, ct_data_a, ct_last_a}, 0);
        check("rst_b_outputs", {block_next_b, hold_out_b, addr_out_b, pt_ready_b, ct_valid_b, ct_data_b, ct_last_b}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 64 x 0xFF back-to-back: ct = 0xFF ^ k, one byte per cycle, one block_next.
        send(0, 8'hFF, 1'b0);
        t0 = cyc;
        for (int k = 1; k < 64; k++) send(0, 8'hFF, 1'b0);
        check("a_throughput_cycles", cyc - t0, 63);
        drain(0);
        check("a_bn_after_full_block", bn_a, 1);

        // pt_last on byte 5, then a new message that must start at address 0.
        for (int k = 0; k < 6; k++) send(0, 8'h10 + 8'(k), k == 5);
        send(0, 8'h20, 1'b0);
        send(0, 8'h21, 1'b1);
        drain(0);
        check("a_bn_after_short_msgs", bn_a, 3);

        // Downstream stall for 3 cycles after the first transfer.
        send(0, 8'hA0, 1'b0);
        fork
            send(0, 8'hA1, 1'b0);
            begin
                ct_ready_a = 1'b0;
                repeat (3) @(negedge clk);
                ct_ready_a = 1'b1;
            end
        join
        send(0, 8'hA2, 1'b1);
        drain(0);
        check("a_bn_after_stall_msg", bn_a, 4);

        // Reset at idx 17 with a pending ct byte.
        for (int k = 0; k < 17; k++) send(0, 8'h30 + 8'(k), 1'b0);
        pt_valid_a = 1'b0;
        ct_ready_a = 1'b0;
        check("a_pending_before_rst", ct_valid_a, 1);
        #3 rst_n = 1'b0;
        #1;
        check("a_async_rst_outputs", {block_next_a, hold_out_a, addr_out_a, pt_ready_a, ct_valid_a, ct_data_a, ct_last_a}, 0);
        sb_a.delete();
        exp_a = 0;
        block_ready_a = 1'b0;
        ct_ready_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 check("a_wait_after_rst", {hold_out_a, addr_out_a}, 0);
        end
        block_ready_a = 1'b1;
        send(0, 8'h55, 1'b0);
        send(0, 8'h66, 1'b1);
        drain(0);
        check("a_bn_after_rst_msg", bn_a, 5);

        // Four-byte blocks: 10 bytes, block_next after bytes 4 and 8.
        for (int k = 0; k < 10; k++) send(1, 8'(k) + 8'h40, 1'b0);
        drain(1);
        check("b_bn_count", bn_b, 2);
        check("b_popped", popped_b, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
